// File: rtl/rf_scoreboard_if.sv
// rtl/rf_scoreboard_if.sv - decode/writeback bundle for rf_scoreboard
// master: decode and writeback side (drives requests, receives read data and stall)
// slave : rf_scoreboard (receives requests, drives read data and stall)
//   i_rf_wr, i_wr_addr, i_wb_data          writeback write port
//   i_rd_en, i_rs1_addr, i_rs2_addr        decode read request
//   o_rs1_data, o_rs2_data, o_rd_valid     registered read response
//   i_issue, i_issue_rd                    decode issue of a destination register
//   o_stall                                combinational hazard flag
interface rf_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            i_rf_wr;
  logic [AW-1:0]   i_wr_addr;
  logic [XLEN-1:0] i_wb_data;
  logic            i_rd_en;
  logic [AW-1:0]   i_rs1_addr;
  logic [AW-1:0]   i_rs2_addr;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic            o_rd_valid;
  logic            i_issue;
  logic [AW-1:0]   i_issue_rd;
  logic            o_stall;

  modport master (
    output i_rf_wr, i_wr_addr, i_wb_data,
    output i_rd_en, i_rs1_addr, i_rs2_addr,
    output i_issue, i_issue_rd,
    input  o_rs1_data, o_rs2_data, o_rd_valid, o_stall
  );

  modport slave (
    input  i_rf_wr, i_wr_addr, i_wb_data,
    input  i_rd_en, i_rs1_addr, i_rs2_addr,
    input  i_issue, i_issue_rd,
    output o_rs1_data, o_rs2_data, o_rd_valid, o_stall
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - register file with busy-bit scoreboard for RAW/WAW stalls
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  rf_scoreboard_if.slave (write, read, issue, stall signals)
// Optional feature macro: RF_BYPASS_EN (same-edge write-to-read bypass and
// early busy release in the stall term).
module rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic            clk,
  input logic            rst,
  rf_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] busy_nxt;
  logic            wr_hit;
  logic            stall_c;
  logic            set_hit;
  logic [XLEN-1:0] rd1_val;
  logic [XLEN-1:0] rd2_val;

  // Writes to x0 are dropped; they neither store data nor clear busy.
  assign wr_hit = bus.i_rf_wr && (bus.i_wr_addr != '0);

  always_comb begin
    clr_mask = '0;
    if (wr_hit) clr_mask[bus.i_wr_addr] = 1'b1;
  end

`ifdef RF_BYPASS_EN
  // A register retiring this cycle no longer blocks decode.
  assign busy_eff = busy & ~clr_mask;
  assign rd1_val  = (wr_hit && (bus.i_wr_addr == bus.i_rs1_addr)) ? bus.i_wb_data : regs[bus.i_rs1_addr];
  assign rd2_val  = (wr_hit && (bus.i_wr_addr == bus.i_rs2_addr)) ? bus.i_wb_data : regs[bus.i_rs2_addr];
`else
  assign busy_eff = busy;
  assign rd1_val  = regs[bus.i_rs1_addr];
  assign rd2_val  = regs[bus.i_rs2_addr];
`endif

  assign stall_c = !rst &&
                   ((bus.i_rd_en && (busy_eff[bus.i_rs1_addr] || busy_eff[bus.i_rs2_addr])) ||
                    (bus.i_issue && busy_eff[bus.i_issue_rd]));
  assign bus.o_stall = stall_c;

  // A stalled issue never claims its destination.
  assign set_hit = bus.i_issue && (bus.i_issue_rd != '0) && !stall_c;

  // Clear is applied before set so a same-register set/clear leaves busy at 1.
  always_comb begin
    busy_nxt = busy & ~clr_mask;
    if (set_hit) busy_nxt[bus.i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy           <= '0;
      bus.o_rs1_data <= '0;
      bus.o_rs2_data <= '0;
      bus.o_rd_valid <= 1'b0;
    end else begin
      if (wr_hit) regs[bus.i_wr_addr] <= bus.i_wb_data;
      busy           <= busy_nxt;
      bus.o_rd_valid <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        bus.o_rs1_data <= rd1_val;
        bus.o_rs2_data <= rd2_val;
      end
    end
  end

  // Address width is fixed by the interface; keep it tied to NREG here too.
  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - scoreboard-style bench for rf_scoreboard
module tb_rf_scoreboard;
  logic clk;
  logic rst;

  rf_scoreboard_if #(.XLEN(32), .NREG(32)) bus ();

  rf_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    string       tag;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_rf_wr    = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wb_data  = '0;
    bus.i_rd_en    = 1'b0;
    bus.i_rs1_addr = '0;
    bus.i_rs2_addr = '0;
    bus.i_issue    = 1'b0;
    bus.i_issue_rd = '0;
  endtask

  // Advance one edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_rf_wr = 1'b1; bus.i_wr_addr = a; bus.i_wb_data = d;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2, input string tag);
    rd_exp_t e;
    bus.i_rd_en = 1'b1; bus.i_rs1_addr = a1; bus.i_rs2_addr = a2;
    e.rs1 = e1; e.rs2 = e2; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic iss(input logic [4:0] r);
    bus.i_issue = 1'b1; bus.i_issue_rd = r;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    #1;
    check32(name, {31'b0, bus.o_stall}, {31'b0, exp});
  endtask

  // Monitor: every valid read response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=valid required=no_response");
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check32({e.tag, "_rs1"}, bus.o_rs1_data, e.rs1);
        check32({e.tag, "_rs2"}, bus.o_rs2_data, e.rs2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    wr(5'd1, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    check32("reset_rd_valid", {31'b0, bus.o_rd_valid}, 32'd0);
    check32("reset_rs1",      bus.o_rs1_data, 32'd0);
    check32("reset_rs2",      bus.o_rs2_data, 32'd0);
    chk_stall("reset_stall", 1'b0);

    rd(5'd1, 5'd2, 32'd0, 32'd0, "rd_x1_x2"); tick();
    wr(5'd0, 32'hDEAD_BEEF); tick();
    rd(5'd0, 5'd0, 32'd0, 32'd0, "rd_x0"); tick();

    wr(5'd5, 32'h1234_5678); tick();
    rd(5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, "rd_x5"); tick();

    wr(5'd7, 32'h0000_0001); tick();
    wr(5'd7, 32'hA5A5_A5A5);
    rd(5'd7, 5'd0, BYP ? 32'hA5A5_A5A5 : 32'h0000_0001, 32'd0, "rd_x7_same_edge"); tick();
    rd(5'd0, 5'd7, 32'd0, 32'hA5A5_A5A5, "rd_x7_next"); tick();

    iss(5'd3); chk_stall("issue_x3_free", 1'b0); tick();
    rd(5'd3, 5'd0, 32'd0, 32'd0, "rd_x3_busy"); chk_stall("raw_x3", 1'b1); tick();
    wr(5'd3, 32'h0000_0033);
    rd(5'd3, 5'd0, BYP ? 32'h0000_0033 : 32'd0, 32'd0, "rd_x3_wb");
    chk_stall("raw_x3_wb_edge", !BYP); tick();
    rd(5'd0, 5'd3, 32'd0, 32'h0000_0033, "rd_x3_after"); chk_stall("raw_x3_after", 1'b0); tick();

    iss(5'd6); wr(5'd6, 32'h0000_0066); chk_stall("set_clr_x6_free", 1'b0); tick();
    rd(5'd6, 5'd6, 32'h0000_0066, 32'h0000_0066, "rd_x6"); chk_stall("set_wins_x6", 1'b1); tick();

    iss(5'd4); tick();
    iss(5'd4); wr(5'd4, 32'h0000_0044); chk_stall("waw_x4_retire", !BYP); tick();
    rd(5'd4, 5'd0, 32'h0000_0044, 32'd0, "rd_x4"); chk_stall("set_wins_x4", BYP); tick();

    iss(5'd9); tick();
    iss(5'd9); chk_stall("waw_x9", 1'b1);
    rst = 1'b1;
    wr(5'd9, 32'h0000_0055); rd(5'd9, 5'd6, 32'd0, 32'd0, "unused");
    void'(exp_q.pop_back());
    chk_stall("stall_in_reset", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    check32("rst_rd_valid", {31'b0, bus.o_rd_valid}, 32'd0);
    rd(5'd9, 5'd6, 32'd0, 32'd0, "rd_x9_post_rst"); iss(5'd4);
    chk_stall("post_rst_stall", 1'b0); tick();

    repeat (3) tick();
    check32("pending_reads", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
